// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq
// Walks the 16-entry instruction memory from address 0. Each 50-bit word
// splits into a 2-bit opcode and three BF16 operands. FMA and FMS words go
// to the FMA datapath over a valid/ready handshake. NOP words are skipped.
// A run ends on a HALT word or after the last programmed entry, and the
// block then pulses done for one cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse; begins a run (ignored unless idle)
//   pc_addr           registered address to instruction memory
//   instr_data        combinational read data for pc_addr
//   op_valid/op_ready operand bundle handshake
//   op_code/op_a/b/c  registered opcode and BF16 operands
//   busy              high in every state except IDLE
//   done              one-cycle end-of-run pulse
//   issued_cnt        bundles accepted in the current/last run
module instr_fetch_seq #(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 50,
    parameter int PROG_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] pc_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        op_code,
    output logic [15:0]       op_a,
    output logic [15:0]       op_b,
    output logic [15:0]       op_c,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   issued_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

    localparam logic [1:0] OPC_NOP  = 2'b01;
    localparam logic [1:0] OPC_HALT = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_addr_q, pc_addr_d;
    logic              op_valid_q, op_valid_d;
    logic [1:0]        op_code_q, op_code_d;
    logic [15:0]       op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [ADDR_W:0]   issued_cnt_q, issued_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_addr_q    <= '0;
            op_valid_q   <= 1'b0;
            op_code_q    <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_addr_q    <= pc_addr_d;
            op_valid_q   <= op_valid_d;
            op_code_q    <= op_code_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_c_q       <= op_c_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_addr_d    = pc_addr_q;
        op_valid_d   = op_valid_q;
        op_code_d    = op_code_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_c_d       = op_c_q;
        issued_cnt_d = issued_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_addr_d    = '0;
                    issued_cnt_d = '0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                op_code_d = instr_data[49:48];
                op_a_d    = instr_data[47:32];
                op_b_d    = instr_data[31:16];
                op_c_d    = instr_data[15:0];
                if (instr_data[49:48] == OPC_HALT) begin
                    state_d = DONE;
                end else if (instr_data[49:48] == OPC_NOP) begin
                    // Skipped words cost one LOAD cycle each; the last-entry
                    // check comes before the increment so pc_addr never wraps.
                    if (pc_addr_q == LAST_ADDR) state_d = DONE;
                    else                        pc_addr_d = pc_addr_q + ADDR_W'(1);
                end else begin
                    op_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Bundle is held unchanged until the datapath takes it.
                if (op_ready) begin
                    op_valid_d   = 1'b0;
                    issued_cnt_d = issued_cnt_q + (ADDR_W+1)'(1);
                    if (pc_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        pc_addr_d = pc_addr_q + ADDR_W'(1);
                        state_d   = LOAD;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pc_addr    = pc_addr_q;
    assign op_valid   = op_valid_q;
    assign op_code    = op_code_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_c       = op_c_q;
    assign issued_cnt = issued_cnt_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        op_ready = 1'b0;
    logic [49:0] mem [16];

    logic [3:0]  pc_addr, pc4;
    logic [49:0] instr_data, instr4;
    logic        op_valid, valid4, busy, busy4, done, done4;
    logic [1:0]  op_code, code4;
    logic [15:0] op_a, op_b, op_c, a4, b4, c4;
    logic [4:0]  issued_cnt, cnt4;

    int errors = 0;
    int checks = 0;

    assign instr_data = mem[pc_addr];
    assign instr4     = mem[pc4];

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_W(4), .INSTR_W(50), .PROG_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc_addr(pc_addr),
        .instr_data(instr_data), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .busy(busy), .done(done), .issued_cnt(issued_cnt));

    instr_fetch_seq #(.ADDR_W(4), .INSTR_W(50), .PROG_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .pc_addr(pc4),
        .instr_data(instr4), .op_valid(valid4), .op_ready(op_ready),
        .op_code(code4), .op_a(a4), .op_b(b4), .op_c(c4),
        .busy(busy4), .done(done4), .issued_cnt(cnt4));

    task automatic fill_fma();
        for (int i = 0; i < 16; i++)
            mem[i] = {2'b00, 16'(i), 16'(2*i), 16'(3*i)};
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pc_addr, op_valid, op_code, op_a, op_b, op_c, busy, done, issued_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pc=%0h v=%0b code=%0h a=%0h b=%0h c=%0h busy=%0b done=%0b cnt=%0d want all zero",
                     pc_addr, op_valid, op_code, op_a, op_b, op_c, busy, done, issued_cnt);
        end
        checks++;
        if ({pc4, valid4, busy4, done4, cnt4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs4: got pc=%0h v=%0b busy=%0b done=%0b cnt=%0d want all zero",
                     pc4, valid4, busy4, done4, cnt4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %0b want 0", busy);
        end
    endtask

    task automatic test_full_run();
        bit ev;
        int k;
        fill_fma();
        op_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 35; c++) begin
            ev = (c >= 2) && (c <= 32) && (c % 2 == 0);
            k  = (c - 2) / 2;
            checks++;
            if (op_valid !== ev) begin
                errors++;
                $display("FAIL full_valid c=%0d: got %0b want %0b", c, op_valid, ev);
            end
            if (ev) begin
                checks++;
                if ({op_code, op_a, op_b, op_c} !== {2'b00, 16'(k), 16'(2*k), 16'(3*k)}) begin
                    errors++;
                    $display("FAIL full_fields c=%0d: got %0h %0h %0h %0h want 0 %0h %0h %0h",
                             c, op_code, op_a, op_b, op_c, 16'(k), 16'(2*k), 16'(3*k));
                end
            end
            checks++;
            if (done !== (c == 33)) begin
                errors++;
                $display("FAIL full_done c=%0d: got %0b want %0b", c, done, c == 33);
            end
            checks++;
            if (busy !== (c <= 33)) begin
                errors++;
                $display("FAIL full_busy c=%0d: got %0b want %0b", c, busy, c <= 33);
            end
            if (c < 35) @(negedge clk);
        end
        checks++;
        if (issued_cnt !== 5'd16) begin
            errors++;
            $display("FAIL full_issued: got %0d want 16", issued_cnt);
        end
        checks++;
        if (pc_addr !== 4'd15) begin
            errors++;
            $display("FAIL full_pc: got %0d want 15", pc_addr);
        end
    endtask

    task automatic test_halt();
        bit ev;
        int k;
        fill_fma();
        mem[3] = {2'b11, 48'h0};
        op_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            ev = (c == 2) || (c == 4) || (c == 6);
            k  = (c - 2) / 2;
            checks++;
            if (op_valid !== ev) begin
                errors++;
                $display("FAIL halt_valid c=%0d: got %0b want %0b", c, op_valid, ev);
            end
            if (ev) begin
                checks++;
                if (op_a !== 16'(k)) begin
                    errors++;
                    $display("FAIL halt_op_a c=%0d: got %0h want %0h", c, op_a, 16'(k));
                end
            end
            checks++;
            if (done !== (c == 8)) begin
                errors++;
                $display("FAIL halt_done c=%0d: got %0b want %0b", c, done, c == 8);
            end
            if (c < 10) @(negedge clk);
        end
        checks++;
        if (issued_cnt !== 5'd3) begin
            errors++;
            $display("FAIL halt_issued: got %0d want 3", issued_cnt);
        end
        checks++;
        if (pc_addr !== 4'd3) begin
            errors++;
            $display("FAIL halt_pc: got %0d want 3", pc_addr);
        end
    endtask

    task automatic test_nop();
        bit ev;
        int k;
        fill_fma();
        mem[1] = {2'b01, 48'hAAAA_BBBB_CCCC};
        mem[2] = {2'b01, 48'h1111_2222_3333};
        op_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 33; c++) begin
            ev = (c == 2) || ((c >= 6) && (c <= 30) && (c % 2 == 0));
            k  = (c == 2) ? 0 : (c - 6) / 2 + 3;
            checks++;
            if (op_valid !== ev) begin
                errors++;
                $display("FAIL nop_valid c=%0d: got %0b want %0b", c, op_valid, ev);
            end
            if (ev) begin
                checks++;
                if ({op_code, op_a, op_c} !== {2'b00, 16'(k), 16'(3*k)}) begin
                    errors++;
                    $display("FAIL nop_fields c=%0d: got %0h %0h %0h want 0 %0h %0h", c, op_code, op_a, op_c, 16'(k), 16'(3*k));
                end
            end
            checks++;
            if (done !== (c == 31)) begin
                errors++;
                $display("FAIL nop_done c=%0d: got %0b want %0b", c, done, c == 31);
            end
            if (c < 33) @(negedge clk);
        end
        checks++;
        if (issued_cnt !== 5'd14) begin
            errors++;
            $display("FAIL nop_issued: got %0d want 14", issued_cnt);
        end
    endtask

    task automatic test_stall();
        fill_fma();
        mem[0] = {2'b10, 16'h3f80, 16'h4000, 16'h4040};
        op_ready = 1'b0;
        pulse_start();
        checks++;
        if (op_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_load_valid: got %0b want 0", op_valid);
        end
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if ({op_valid, op_code, op_a, op_b, op_c} !== {1'b1, 2'b10, 16'h3f80, 16'h4000, 16'h4040}) begin
                errors++;
                $display("FAIL stall_hold c=%0d: got v=%0b %0h %0h %0h %0h want 1 2 3f80 4000 4040",
                         c, op_valid, op_code, op_a, op_b, op_c);
            end
            checks++;
            if (issued_cnt !== 5'd0) begin
                errors++;
                $display("FAIL stall_cnt_pre c=%0d: got %0d want 0", c, issued_cnt);
            end
            if (c == 7) op_ready = 1'b1;
        end
        @(negedge clk);
        op_ready = 1'b0;
        checks++;
        if ({op_valid, issued_cnt} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL stall_accept: got v=%0b cnt=%0d want v=0 cnt=1", op_valid, issued_cnt);
        end
        @(negedge clk);
        checks++;
        if ({op_valid, op_a} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL stall_next: got v=%0b a=%0h want v=1 a=1", op_valid, op_a);
        end
        @(negedge clk);
        checks++;
        if (issued_cnt !== 5'd1) begin
            errors++;
            $display("FAIL stall_single_accept: got %0d want 1", issued_cnt);
        end
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored_and_reset();
        bit ev;
        fill_fma();
        op_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            ev = (c % 2 == 0);
            checks++;
            if (op_valid !== ev) begin
                errors++;
                $display("FAIL restart_valid c=%0d: got %0b want %0b", c, op_valid, ev);
            end
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL restart_busy_done c=%0d: got %0b%0b want 10", c, busy, done);
            end
            if (c == 17) begin
                checks++;
                if (pc_addr !== 4'd8) begin
                    errors++;
                    $display("FAIL restart_pc: got %0d want 8", pc_addr);
                end
            end
            start = (c == 15);
            if (c < 20) @(negedge clk);
        end
        checks++;
        if ({pc_addr, op_a} !== {4'd9, 16'd9}) begin
            errors++;
            $display("FAIL pre_reset_pc: got %0d a=%0h want 9", pc_addr, op_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_addr, op_valid, op_code, op_a, op_b, op_c, busy, done, issued_cnt} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got pc=%0h v=%0b a=%0h busy=%0b done=%0b cnt=%0d want all zero",
                     pc_addr, op_valid, op_a, busy, done, issued_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({op_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset c=%0d: got v=%0b busy=%0b done=%0b want 000", c, op_valid, busy, done);
            end
        end
    endtask

    task automatic test_prog_len4();
        bit ev;
        int k;
        int done_cnt = 0;
        fill_fma();
        op_ready = 1'b1;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ev = (c >= 2) && (c <= 8) && (c % 2 == 0);
            k  = (c - 2) / 2;
            checks++;
            if (valid4 !== ev) begin
                errors++;
                $display("FAIL len4_valid c=%0d: got %0b want %0b", c, valid4, ev);
            end
            if (ev) begin
                checks++;
                if ({code4, a4, b4, c4} !== {2'b00, 16'(k), 16'(2*k), 16'(3*k)}) begin
                    errors++;
                    $display("FAIL len4_fields c=%0d: got %0h %0h %0h %0h want 0 %0h", c, code4, a4, b4, c4, 16'(k));
                end
            end
            checks++;
            if (pc4 > 4'd3) begin
                errors++;
                $display("FAIL len4_pc_bound c=%0d: got %0d want <=3", c, pc4);
            end
            checks++;
            if (busy4 !== (c <= 9)) begin
                errors++;
                $display("FAIL len4_busy c=%0d: got %0b want %0b", c, busy4, c <= 9);
            end
            if (done4) done_cnt++;
            checks++;
            if (done4 !== (c == 9)) begin
                errors++;
                $display("FAIL len4_done c=%0d: got %0b want %0b", c, done4, c == 9);
            end
            if (c < 12) @(negedge clk);
        end
        checks++;
        if ({pc4, cnt4, done_cnt[3:0]} !== {4'd3, 5'd4, 4'd1}) begin
            errors++;
            $display("FAIL len4_final: got pc=%0d cnt=%0d dones=%0d want 3 4 1", pc4, cnt4, done_cnt);
        end
    endtask

    initial begin
        fill_fma();
        test_reset();
        test_full_run();
        test_halt();
        test_nop();
        test_stall();
        test_start_ignored_and_reset();
        test_prog_len4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        if (errors == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule
